alu: RTL and testbench

Eighteen-bit arithmetic/logic unit of the Proc18 execute stage. Given a 4-bit operation code and two 18-bit operands, it produces an 18-bit result, a zero flag and a sign/shift-out flag. Outputs are registered once on the clock, so the result is available one cycle after the operands and opcode are presented. The processor's register-write and branch logic consume the result and flags.

---
 rtl/alu.sv | 94 +++++++++
 tb/tb_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Proc18 execute-stage ALU: 18-bit operands, octal opcodes, one-cycle registered result and flags.
module alu (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Op,
  input  logic [17:0] SData,
  input  logic [17:0] DData,
  output logic [17:0] Result,
  output logic        ZOut,
  output logic        FOut
);

  typedef enum logic [3:0] {
    OP_CMP  = 4'o00,
    OP_PAS  = 4'o01,
    OP_NEG  = 4'o02,
    OP_INV  = 4'o03,
    OP_SHR  = 4'o04,
    OP_SHL  = 4'o05,
    OP_PD6  = 4'o06,
    OP_PD7  = 4'o07,
    OP_PD10 = 4'o10,
    OP_ADD  = 4'o11,
    OP_SUB  = 4'o12,
    OP_MUL  = 4'o13,
    OP_AND  = 4'o14,
    OP_OR   = 4'o15,
    OP_XOR  = 4'o16,
    OP_PD17 = 4'o17
  } op_t;

  op_t         op_sel;
  logic [4:0]  shamt;
  logic [18:0] shr_ext;
  logic [18:0] shl_ext;
  logic [17:0] prod;
  logic [17:0] res;
  logic        shift_out;
  logic        is_shift;

  assign op_sel = op_t'(Op);
  assign shamt  = SData[4:0];

  // One guard bit below (SHR) or above (SHL) D catches the last bit shifted out.
  // n = 0 leaves the guard at 0, n > 18 pushes everything out.
  assign shr_ext = {DData, 1'b0} >> shamt;
  assign shl_ext = {1'b0, DData} << shamt;

  // Low 18 bits of a signed product equal those of the unsigned product.
  assign prod = DData * SData;

  // Combinational operation select and shift-out flag.
  always_comb begin
    res       = DData;
    shift_out = 1'b0;
    is_shift  = 1'b0;
    case (op_sel)
      OP_CMP, OP_SUB: res = DData - SData;
      OP_PAS:         res = SData;
      OP_NEG:         res = '0 - SData;
      OP_INV:         res = ~SData;
      OP_SHR: begin
        res       = shr_ext[18:1];
        shift_out = shr_ext[0];
        is_shift  = 1'b1;
      end
      OP_SHL: begin
        res       = shl_ext[17:0];
        shift_out = shl_ext[18];
        is_shift  = 1'b1;
      end
      OP_ADD:         res = DData + SData;
      OP_MUL:         res = prod;
      OP_AND:         res = DData & SData;
      OP_OR:          res = DData | SData;
      OP_XOR:         res = DData ^ SData;
      default:        res = DData;
    endcase
  end

  // Output registers, cleared asynchronously by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Result <= '0;
      ZOut   <= 1'b0;
      FOut   <= 1'b0;
    end else begin
      Result <= res;
      ZOut   <= (res == '0);
      FOut   <= is_shift ? shift_out : res[17];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes expected responses, monitor pops one per clock.
module tb_alu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  Op;
  logic [17:0] SData;
  logic [17:0] DData;
  logic [17:0] Result;
  logic        ZOut;
  logic        FOut;

  alu dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Op     (Op),
    .SData  (SData),
    .DData  (DData),
    .Result (Result),
    .ZOut   (ZOut),
    .FOut   (FOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [17:0] r;
    logic        z;
    logic        f;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [17:0] d;
    logic [17:0] s;
    logic [17:0] r;
    logic        z;
    logic        f;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [17:0] er, input logic ez, input logic ef);
    n_cmp++;
    if (Result !== er || ZOut !== ez || FOut !== ef) begin
      n_bad++;
      $display("FAIL %s: got Result=%o Z=%b F=%b, expected Result=%o Z=%b F=%b",
               name, Result, ZOut, FOut, er, ez, ef);
    end
  endtask

  // Monitor: the ALU has no valid strobe, so each pending expectation is due one edge later.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, e.r, e.z, e.f);
      end
    end
  end

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [3:0] op, input logic [17:0] d,
                         input logic [17:0] s, input logic [17:0] r, input logic z, input logic f);
    vec_t v;
    v.name = name; v.op = op; v.d = d; v.s = s; v.r = r; v.z = z; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic drive(input string name, input logic [3:0] op, input logic [17:0] d,
                       input logic [17:0] s, input logic [17:0] r, input logic z, input logic f);
    exp_t e;
    Op = op; DData = d; SData = s;
    e.name = name; e.r = r; e.z = z; e.f = f;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int unsigned cyc = 0;
    while (sb.size() > 0 && cyc < 10) begin
      @(posedge Clk);
      cyc++;
    end
    #2;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %0d responses outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // CMP/SUB
    add_vec("cmp_23_5",  4'o00, 18'd23, 18'd5,  18'd18,     1'b0, 1'b0);
    add_vec("cmp_5_23",  4'o00, 18'd5,  18'd23, 18'o777756, 1'b0, 1'b1);
    add_vec("sub_eq",    4'o12, 18'd23, 18'd23, 18'd0,      1'b1, 1'b0);
    add_vec("sub_5_23",  4'o12, 18'd5,  18'd23, 18'o777756, 1'b0, 1'b1);
    // PAS/NEG/INV
    add_vec("pas",       4'o01, 18'd0,  18'o525252, 18'o525252, 1'b0, 1'b1);
    add_vec("neg_23",    4'o02, 18'd0,  18'd23,     18'o777751, 1'b0, 1'b1);
    add_vec("neg_0",     4'o02, 18'd7,  18'd0,      18'd0,      1'b1, 1'b0);
    add_vec("inv_ones",  4'o03, 18'd0,  18'o777777, 18'd0,      1'b1, 1'b0);
    add_vec("inv_0",     4'o03, 18'd0,  18'd0,      18'o777777, 1'b0, 1'b1);
    // Shifts
    add_vec("shr_a",     4'o04, 18'o252525, 18'd3,      18'o025252, 1'b0, 1'b1);
    add_vec("shr_b",     4'o04, 18'o525252, 18'd3,      18'o052525, 1'b0, 1'b0);
    add_vec("shl_a",     4'o05, 18'o252525, 18'd3,      18'o525250, 1'b0, 1'b0);
    add_vec("shl_b",     4'o05, 18'o525252, 18'd3,      18'o252520, 1'b0, 1'b1);
    add_vec("shr_n0",    4'o04, 18'o525252, 18'd0,      18'o525252, 1'b0, 1'b0);
    add_vec("shl_n0",    4'o05, 18'o525252, 18'd0,      18'o525252, 1'b0, 1'b0);
    add_vec("shl_n20",   4'o05, 18'o525252, 18'd20,     18'd0,      1'b1, 1'b0);
    add_vec("shr_n20",   4'o04, 18'o777777, 18'd20,     18'd0,      1'b1, 1'b0);
    add_vec("shr_n18",   4'o04, 18'o400001, 18'd18,     18'd0,      1'b1, 1'b1);
    add_vec("shl_n18",   4'o05, 18'o400001, 18'd18,     18'd0,      1'b1, 1'b1);
    add_vec("shl_n19",   4'o05, 18'o777777, 18'd19,     18'd0,      1'b1, 1'b0);
    add_vec("shr_n1",    4'o04, 18'o000001, 18'd1,      18'd0,      1'b1, 1'b1);
    add_vec("shr_hi_s",  4'o04, 18'o252525, 18'o777743, 18'o025252, 1'b0, 1'b1);
    // ADD/MUL
    add_vec("add_pos",   4'o11, 18'o777773, 18'd23,     18'd18,     1'b0, 1'b0);
    add_vec("add_neg",   4'o11, 18'o777773, 18'o777751, 18'o777744, 1'b0, 1'b1);
    add_vec("mul_neg",   4'o13, 18'o777773, 18'd23,     18'o777615, 1'b0, 1'b1);
    add_vec("mul_pos",   4'o13, 18'o777773, 18'o777751, 18'd115,    1'b0, 1'b0);
    // Logic and pass-D codes
    add_vec("and",       4'o14, 18'o543210, 18'o222222, 18'o002200, 1'b0, 1'b0);
    add_vec("or",        4'o15, 18'o543210, 18'o222222, 18'o763232, 1'b0, 1'b1);
    add_vec("xor",       4'o16, 18'o543210, 18'o222222, 18'o761032, 1'b0, 1'b1);
    add_vec("pass_06",   4'o06, 18'o543210, 18'o222222, 18'o543210, 1'b0, 1'b1);
    add_vec("pass_07",   4'o07, 18'o123456, 18'o222222, 18'o123456, 1'b0, 1'b0);
    add_vec("pass_10",   4'o10, 18'd0,      18'o222222, 18'd0,      1'b1, 1'b0);
    add_vec("pass_17",   4'o17, 18'o700000, 18'o222222, 18'o700000, 1'b0, 1'b1);

    Reset = 1'b1;
    Op = 4'o01; DData = '0; SData = 18'o777777;
    #1;
    check("reset_state", 18'd0, 1'b0, 1'b0);

    @(negedge Clk);
    Reset = 1'b0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge Clk);
      drive(vecs[i].name, vecs[i].op, vecs[i].d, vecs[i].s, vecs[i].r, vecs[i].z, vecs[i].f);
    end
    drain("drain_vectors");

    // Reset between edges clears the outputs at once and holds them through an edge.
    @(negedge Clk);
    drive("rst_pre_add", 4'o11, 18'd5, 18'd23, 18'd28, 1'b0, 1'b0);
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("rst_async_clear", 18'd0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    check("rst_hold", 18'd0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_release_wait", 18'd0, 1'b0, 1'b0);
    drive("rst_post_add", 4'o11, 18'd5, 18'd23, 18'd28, 1'b0, 1'b0);
    drain("drain_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
